// File: rtl/dmem_preloader.sv
// Boot-time data-memory loader: takes a valid/ready word stream, writes it to consecutive
// word addresses, then releases the CPU from reset after a short hold.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | after reset; CPU held, waiting for start
// LOAD  | accepting stream words and writing them to data memory
// HOLD  | all words written; CPU held for RESET_HOLD more edges
// RUN   | CPU released; a new start reloads with the CPU held again
module dmem_preloader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int RESET_HOLD = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HOLD_W-1:0]     HOLD_TC   = HOLD_W'(RESET_HOLD - 1);
  localparam logic [HOLD_W-1:0]     HOLD_ONE  = HOLD_W'(1);
  localparam logic [ADDR_WIDTH:0]   MAX_WORDS = (ADDR_WIDTH + 1)'(1) << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] ptr, ptr_nxt;
  logic [ADDR_WIDTH:0]   remaining, remaining_nxt;
  logic [ADDR_WIDTH:0]   words_nxt;
  logic [HOLD_W-1:0]     hold_cnt, hold_nxt;
  logic [ADDR_WIDTH:0]   count_clamped;

  // A load can never cover more than the whole memory, so words_loaded stays bounded.
  assign count_clamped = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      remaining    <= '0;
      words_loaded <= '0;
      hold_cnt     <= '0;
    end else begin
      state        <= state_nxt;
      ptr          <= ptr_nxt;
      remaining    <= remaining_nxt;
      words_loaded <= words_nxt;
      hold_cnt     <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    remaining_nxt = remaining;
    words_nxt     = words_loaded;
    hold_nxt      = hold_cnt;
    in_ready      = 1'b0;
    mem_we        = 1'b0;

    case (state)
      ST_IDLE, ST_RUN: begin
        if (start) begin
          ptr_nxt       = base_addr;
          remaining_nxt = count_clamped;
          words_nxt     = '0;
          hold_nxt      = '0;
          state_nxt     = (count_clamped != '0) ? ST_LOAD : ST_HOLD;
        end
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mem_we        = 1'b1;
          ptr_nxt       = ptr + PTR_ONE;
          remaining_nxt = remaining - CNT_ONE;
          words_nxt     = words_loaded + CNT_ONE;
          if (remaining == CNT_ONE) begin
            state_nxt = ST_HOLD;
            hold_nxt  = '0;
          end
        end
      end
      ST_HOLD: begin
        if (hold_cnt == HOLD_TC) state_nxt = ST_RUN;
        else                     hold_nxt  = hold_cnt + HOLD_ONE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // No write may slip through on a reset cycle, even mid-load.
    if (reset) begin
      in_ready = 1'b0;
      mem_we   = 1'b0;
    end
  end

  assign mem_addr  = ptr;
  assign mem_wdata = in_data;
  assign cpu_reset = (state != ST_RUN);
  assign busy      = (state == ST_LOAD) || (state == ST_HOLD);
  assign done      = (state == ST_RUN);

endmodule
